// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch: issues line reads to a 1-cycle imem,
// buffers returned pairs in a small FIFO, handles branch redirects.
// Ports: clock_i/reset_n_i, imem_addr_o/imem_stall_o/imem_data_i,
//        redirect_i/redirect_addr_i, out_valid_o/out_ready_i + pair fields.
module fetch_unit #(
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 4,
    parameter int RESET_LINE = 0
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              imem_stall_o,
    input  logic [63:0]       imem_data_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_inst0_o,
    output logic [31:0]       out_inst1_o,
    output logic              out_v0_o,
    output logic              out_v1_o,
    output logic [31:0]       out_pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] RST_L = ADDR_W'(RESET_LINE);

    typedef struct packed {
        logic [63:0]       data;
        logic              v0;
        logic [ADDR_W-1:0] line;
    } ent_t;

    logic [ADDR_W-1:0] fetch_line_q, fetch_line_d;
    logic [ADDR_W-1:0] infl_line_q, infl_line_d;
    logic              inflight_q, inflight_d;
    logic              infl_skip_q, infl_skip_d;
    logic              skip_q, skip_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    ent_t              fifo_q [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] credit;
    ent_t          head;

    // Bits of the redirect target outside the line/slot fields are ignored.
    logic unused_addr;
    assign unused_addr = ^{redirect_addr_i[31:ADDR_W+3],
                           redirect_addr_i[1:0]};

    // A request is only issued if a FIFO slot is reserved for its response.
    assign credit = count_q + CW'(inflight_q);
    assign issue  = reset_n_i & ~redirect_i & (credit < CW'(DEPTH));
    assign push   = inflight_q & ~redirect_i;
    assign pop    = out_valid_o & out_ready_i & ~redirect_i;

    assign imem_addr_o  = reset_n_i ? fetch_line_q : RST_L;
    assign imem_stall_o = ~issue;

    assign head        = fifo_q[rd_q];
    assign out_valid_o = (count_q != '0);
    assign out_inst0_o = out_valid_o ? head.data[31:0] : '0;
    assign out_inst1_o = out_valid_o ? head.data[63:32] : '0;
    assign out_v0_o    = out_valid_o & head.v0;
    assign out_v1_o    = out_valid_o;
    assign out_pc_o    = out_valid_o ? 32'({head.line, 3'b000}) : '0;

    always_comb begin
        fetch_line_d = fetch_line_q;
        infl_line_d  = infl_line_q;
        infl_skip_d  = infl_skip_q;
        inflight_d   = issue;
        skip_d       = skip_q;
        count_d      = count_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        if (redirect_i) begin
            fetch_line_d = redirect_addr_i[ADDR_W+2:3];
            skip_d       = redirect_addr_i[2];
            count_d      = '0;
            rd_d         = '0;
            wr_d         = '0;
        end else begin
            if (issue) begin
                fetch_line_d = fetch_line_q + ADDR_W'(1);
                infl_line_d  = fetch_line_q;
                infl_skip_d  = skip_q;
                skip_d       = 1'b0;
            end
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            fetch_line_q <= RST_L;
            infl_line_q  <= '0;
            infl_skip_q  <= 1'b0;
            inflight_q   <= 1'b0;
            skip_q       <= 1'b0;
            count_q      <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
        end else begin
            fetch_line_q <= fetch_line_d;
            infl_line_q  <= infl_line_d;
            infl_skip_q  <= infl_skip_d;
            inflight_q   <= inflight_d;
            skip_q       <= skip_d;
            count_q      <= count_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_n_i && push) begin
            fifo_q[wr_q] <= '{data: imem_data_i,
                              v0:   ~infl_skip_q,
                              line: infl_line_q};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_n_i) begin
            assert (!(push && count_q == CW'(DEPTH)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: imem model plus a scoreboard of
// expected instruction pairs checked whenever decode accepts one.
module tb_fetch_unit;

    localparam int AW = 10;
    localparam int RL = 0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic          imem_stall;
    logic [63:0]   imem_data = '0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_inst0;
    logic [31:0]   out_inst1;
    logic          out_v0;
    logic          out_v1;
    logic [31:0]   out_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        v0;
    } exp_t;

    exp_t sb[$];

    fetch_unit #(.ADDR_W(AW), .DEPTH(4), .RESET_LINE(RL)) dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .imem_addr_o    (imem_addr),
        .imem_stall_o   (imem_stall),
        .imem_data_i    (imem_data),
        .redirect_i     (redirect),
        .redirect_addr_i(redirect_addr),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_inst0_o    (out_inst0),
        .out_inst1_o    (out_inst1),
        .out_v0_o       (out_v0),
        .out_v1_o       (out_v1),
        .out_pc_o       (out_pc)
    );

    always #5 clk = ~clk;

    // Line n holds {2n+1, 2n}; output holds while stalled.
    always @(posedge clk) begin
        if (!imem_stall)
            imem_data <= {32'(imem_addr) * 2 + 32'd1, 32'(imem_addr) * 2};
    end

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic expect_lines(input int start, input int n, input bit skip);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int l;
            l = (start + k) % (1 << AW);
            e.pc = 32'(l * 8);
            e.i0 = 32'(2 * l);
            e.i1 = 32'(2 * l + 1);
            e.v0 = !(k == 0 && skip);
            sb.push_back(e);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (!rst_n) return;
        if (out_valid) begin
            if (out_ready && !redirect && sb.size() > 0) begin
                e = sb.pop_front();
                check("pc", out_pc, e.pc);
                check("inst0", out_inst0, e.i0);
                check("inst1", out_inst1, e.i1);
                check("v0", out_v0, e.v0);
                check("v1", out_v1, 1);
            end
        end else begin
            check("idle_pc_i0", {out_pc, out_inst0}, 0);
            check("idle_i1_v", {30'b0, out_v0, out_v1, out_inst1}, 0);
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            half();
            fin();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        sb.delete();
        half();
        check("rst_stall", imem_stall, 1);
        check("rst_addr", imem_addr, RL);
        fin();
        adv(1);
        rst_n = 1'b1;
    endtask

    // Called at the start of cycle 0 after reset release, ready high.
    task automatic boot_check();
        expect_lines(0, 8, 0);
        half();
        check("c0_addr", imem_addr, 0);
        check("c0_stall", imem_stall, 0);
        check("c0_valid", out_valid, 0);
        fin();
        half();
        check("c1_valid", out_valid, 0);
        check("c1_addr", imem_addr, 1);
        fin();
        repeat (8) begin
            half();
            check("stream_valid", out_valid, 1);
            fin();
        end
        check("boot_drain", sb.size(), 0);
    endtask

    task automatic redirect_to(input logic [31:0] a, input int n);
        sb.delete();
        expect_lines(int'(a[AW+2:3]), n, a[2]);
        redirect = 1'b1;
        redirect_addr = a;
        adv(1);
        redirect = 1'b0;
        half();
        check("rd_gap1", out_valid, 0);
        fin();
        half();
        check("rd_gap2", out_valid, 0);
        fin();
        half();
        check("rd_first", out_valid, 1);
        fin();
        adv(n + 1);
        check("rd_drain", sb.size(), 0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Free-running fetch from reset.
        out_ready = 1'b1;
        do_reset();
        boot_check();

        // Backpressure: fill the FIFO, then drain in order.
        out_ready = 1'b0;
        do_reset();
        expect_lines(0, 9, 0);
        adv(8);
        half();
        check("bp_stall", imem_stall, 1);
        check("bp_addr", imem_addr, 4);
        check("bp_valid", out_valid, 1);
        fin();
        out_ready = 1'b1;
        adv(14);
        check("bp_drain", sb.size(), 0);

        // Redirect to an odd slot mid-stream.
        do_reset();
        expect_lines(0, 3, 0);
        adv(5);
        check("pre_rd_drain", sb.size(), 0);
        redirect_to(32'h0000_0014, 4);

        // Redirect right after the first issue: response dropped.
        do_reset();
        adv(1);
        redirect_to(32'h0000_0040, 4);

        // Line address wrap.
        redirect_to(32'h0000_1FF8, 3);

        // Back-to-back redirects: last one wins.
        redirect = 1'b1;
        redirect_addr = 32'h0000_0100;
        adv(1);
        redirect_to(32'h0000_0204, 4);

        // Reset with a partly full FIFO and a redirect in the same cycle.
        out_ready = 1'b0;
        do_reset();
        adv(4);
        half();
        check("mid_valid", out_valid, 1);
        fin();
        rst_n = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h0000_0080;
        adv(1);
        rst_n = 1'b1;
        redirect = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        boot_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch initiator for the dual-issue front end. It drives line addresses into the synchronous 64-bit instruction memory (simple_imem: 1-cycle read latency, output held while stalled) and captures the returned instruction pairs. Captured pairs go into a small FIFO that decode drains with a valid/ready handshake. It also handles branch redirects, including entry at the odd slot of a line.

Parameters:
ADDR_W, 10, line-address width (one line = 64 bits = two 32-bit instructions)
DEPTH, 4, FIFO entries (power of two, >= 2)
RESET_LINE, 0, line fetched first after reset

Ports:
clock_i  input  1  clock; all state updates on rising edge
reset_n_i  input  1  synchronous, active-low reset
imem_addr_o  output  ADDR_W  line address presented to instruction memory
imem_stall_o  output  1  1 = no request this cycle (memory holds output)
imem_data_i  input  64  read data, valid the cycle after an issued request
redirect_i  input  1  flush and restart fetch at redirect_addr_i
redirect_addr_i  input  32  byte target; line = [ADDR_W+2:3], slot = [2]
out_valid_o  output  1  head pair valid
out_ready_i  input  1  decode accepts head pair
out_inst0_o  output  32  lower-address instruction (imem_data_i[31:0])
out_inst1_o  output  32  upper-address instruction (imem_data_i[63:32])
out_v0_o  output  1  slot 0 valid (0 only for an odd-slot redirect target)
out_v1_o  output  1  slot 1 valid (always 1 when out_valid_o)
out_pc_o  output  32  byte PC of slot 0 = {zero-extend(line), 3'b000}

Behaviour:
- State: fetch_line_q, inflight_q (+ its line and skip bit), skip_q, FIFO (DEPTH entries, count_q, rd/wr pointers).
- Reset (reset_n_i low at an edge):
  - fetch_line_q=RESET_LINE; inflight_q=0; skip_q=0; FIFO empty.
  - Reset has priority over redirect_i and any handshake.
- Outputs while reset_n_i is low: imem_stall_o=1, imem_addr_o=RESET_LINE.
- Outputs while the FIFO is empty: out_valid_o=0; out_inst0_o, out_inst1_o, out_pc_o, out_v0_o, out_v1_o all 0.
- Issue (combinational): issue = reset_n_i & ~redirect_i & (count_q + inflight_q < DEPTH).
  - imem_addr_o = fetch_line_q; imem_stall_o = ~issue.
  - On issue: inflight_q<=1, recording line and skip_q; skip_q<=0; fetch_line_q<=fetch_line_q+1, wrapping 2^ADDR_W-1 -> 0.
  - Without issue: inflight_q<=0.
- Capture:
  - If inflight_q and no redirect_i: push {imem_data_i, v0 = ~recorded skip, pc of recorded line}.
  - Latency: issue in cycle t -> push at end of t+1 -> out_valid_o in t+2.
- Pop: when out_valid_o & out_ready_i and no redirect_i. Push and pop in the same cycle leave count_q unchanged.
- The credit rule means the FIFO never overflows. Push into a full FIFO is an assertion failure.
- Redirect_i (single cycle, wins over push, pop and issue):
  - FIFO cleared; inflight_q<=0, so the response arriving next cycle is dropped.
  - fetch_line_q<=target line; skip_q<=slot bit.
  - Issue of the target happens the next cycle. First target pair is visible 3 cycles after redirect_i.
- Back-to-back redirects: the last one wins. No stale pair ever reaches the output.
- Steady state with out_ready_i=1: one pair per cycle, no bubbles.

Test Plan:
- Memory line n = {32'(2n+1), 32'(2n)}, out_ready_i=1, release reset at cycle 0:
  - imem_addr_o=0 and imem_stall_o=0 in cycle 0.
  - out_valid_o first high in cycle 2 with pc 0x0, inst0=0, inst1=1, v0=v1=1.
  - Then pc 0x8, 0x10, ... every cycle.
- Backpressure, out_ready_i=0 from reset:
  - After 4 pushes, count=4, imem_stall_o=1, imem_addr_o held at 4.
  - Raise ready: pairs pc 0x0..0x18 then 0x20 in order, none duplicated or lost.
- Redirect to 0x0000_0014 mid-stream:
  - out_valid_o=0 for the next 2 cycles.
  - 3rd cycle: pc 0x10, v0=0, v1=1, inst1=5.
  - Next cycle: pc 0x18, v0=1.
- Redirect in the cycle after an issue:
  - The arriving imem_data_i is not pushed.
  - Only target-line pairs appear afterwards.
- Wrap: redirect to 0x1FF8 -> outputs pc 0x1FF8, then 0x0000, then 0x0008.
- Reset mid-operation with FIFO holding 3 pairs and redirect_i=1 in the same cycle:
  - Next cycle out_valid_o=0 and imem_addr_o=RESET_LINE.
  - Fetch restarts exactly as in scenario 1.
